// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage pipeline.
// Resolves load-use and branch-operand stalls, taken-branch/jump flushes,
// and the multi-cycle multiply that occupies EX. It also counts stall and
// flush cycles in saturating counters.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt      source operands of the ID instruction
//   id_is_branch, branch_taken    branch in ID and its comparator result
//   id_is_mul, jump               multiply / jump in ID
//   ex_mem_read, ex_reg_write,
//   ex_rd                         EX producer information
//   mem_mem_read, mem_rd          MEM load producer information
//   pc_hold, ifid_hold, ifid_flush,
//   idex_flush, idex_hold,
//   exmem_flush                   pipeline controls (combinational)
//   mul_busy                      multiply occupying EX (combinational)
//   stall_cnt, flush_cnt          saturating performance counters (registered)
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_is_mul,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_hold,
  output logic        exmem_flush,
  output logic        mul_busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MCNT_W = 4;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [MCNT_W-1:0]  mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic match_ex, match_mem, load_use, br_data, stall;

  // Register 0 never carries a dependency.
  assign match_ex  = (ex_rd != REG_W'(0)) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign match_mem = (mem_rd != REG_W'(0)) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  assign load_use = ex_mem_read && match_ex;
  assign br_data  = id_is_branch &&
                    ((ex_reg_write && match_ex) || (mem_mem_read && match_mem));
  assign stall    = load_use || br_data;

  // State register and multiply countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mcnt_q  <= MCNT_W'(0);
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next state and pipeline controls; MUL_WAIT outranks stall outranks flush.
  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_hold   = 1'b0;
    exmem_flush = 1'b0;
    mul_busy    = 1'b0;

    case (state_q)
      RUN: begin
        if (stall) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end else begin
          ifid_flush = jump || (id_is_branch && branch_taken);
          if (id_is_mul) begin
            state_d = MUL_WAIT;
            mcnt_d  = MCNT_W'(MUL_LAT - 1);
          end
        end
      end
      MUL_WAIT: begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_flush = 1'b1;
        mul_busy    = 1'b1;
        mcnt_d      = mcnt_q - MCNT_W'(1);
        if (mcnt_q == MCNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Controls are forced quiet for the whole reset window.
    if (!rst_n) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      idex_hold   = 1'b0;
      exmem_flush = 1'b0;
      mul_busy    = 1'b0;
    end
  end

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= CNT_W'(0);
      flush_cnt_q <= CNT_W'(0);
    end else begin
      if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the hold and flush inputs of the IF/ID register and the PC, and drives the bubble controls of ID/EX and EX/MEM. It resolves load-use and branch-operand stalls, taken-branch and jump flushes, and a multi-cycle multiply occupying EX. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MUL_LAT, 4: cycles a multiply occupies EX; legal range 2..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID holds beq/bne; compared in ID.
- id_is_mul  in  1  ID holds a multiply.
- branch_taken  in  1  ID comparator result; meaningful only with id_is_branch.
- jump  in  1  ID holds j/jal/jr.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_rd  in  5  destination register of the EX instruction; for loads this is rt.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_rd  in  5  destination register of the MEM instruction.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- ifid_flush  out  1  zero IF/ID instruction (nop).
- idex_flush  out  1  load a bubble into ID/EX.
- idex_hold  out  1  freeze ID/EX.
- exmem_flush  out  1  load a bubble into EX/MEM.
- mul_busy  out  1  FSM in MUL_WAIT.
- stall_cnt  out  16  saturating count of cycles with pc_hold=1.
- flush_cnt  out  16  saturating count of cycles with ifid_flush=1.

## Operation
- FSM states: RUN and MUL_WAIT. A 4-bit down-counter `mcnt` accompanies the FSM.
- Definitions (compare value r, where r≠0 is required for a match):
  - match(r) = r==id_rs || (id_uses_rt && r==id_rt).
  - load_use = ex_mem_read && match(ex_rd).
  - br_data = id_is_branch && ((ex_reg_write && match(ex_rd)) || (mem_mem_read && match(mem_rd))).
  - stall = load_use || br_data.
- Priority: MUL_WAIT > stall > control flush.
- **In MUL_WAIT:**
  - Outputs: pc_hold=ifid_hold=idex_hold=exmem_flush=1, and all other flushes are 0.
  - branch_taken and jump are ignored.
  - mcnt decrements each cycle. When mcnt==1, the next state is RUN.
- **In RUN with stall=1:**
  - Outputs: pc_hold=ifid_hold=idex_flush=1, and ifid_flush=0.
  - IF/ID gives flush priority over hold, so ifid_flush and ifid_hold are never asserted together.
- **In RUN with stall=0:**
  - ifid_flush = jump || (id_is_branch && branch_taken).
  - All holds are 0.
  - If id_is_mul=1, the next state is MUL_WAIT with mcnt=MUL_LAT-1.
- A multiply held by a stall does not enter MUL_WAIT until the stall clears.
- All outputs except the counters are combinational from state and inputs. The counters are registered.
- Counters increment on the clock edge while their condition holds, saturate at 16'hFFFF, and never wrap.

## Timing
- Reset while rst_n=0: state=RUN, mcnt=0, stall_cnt=0, flush_cnt=0, and all hold, flush and mul_busy outputs are forced to 0 regardless of inputs.
- Reset takes effect mid-MUL_WAIT immediately and asynchronously; after release the FSM is in RUN.
- Stall and flush outputs are asserted in the same cycle as the causing inputs, so the registers sample them at the next edge. Latency is 0 cycles.
- Multiply timing:
  - Multiply in ID at cycle t with stall=0: it enters EX at edge t.
  - Cycles t+1 .. t+MUL_LAT-1 are MUL_WAIT.
  - Cycle t+MUL_LAT is RUN again, giving MUL_LAT-1 hold cycles.
- A load-use stall lasts exactly 1 cycle because the load advances to MEM.
- br_data on an ALU producer lasts 1 cycle. On a load producer it lasts 2 cycles: first via ex_mem_read/ex_reg_write, then via mem_mem_read.
- stall_cnt reflects the cycle k increment at cycle k+1.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=8, id_rs=8 -> pc_hold=ifid_hold=idex_flush=1 for one cycle and stall_cnt=1. The same stimulus with ex_rd=0 produces no stall.
- **Taken branch:** id_is_branch=1, branch_taken=1, no hazards -> ifid_flush=1, ifid_hold=0, flush_cnt increments. A jump gives the same result.
- **Branch after load:** lw $9 followed by beq $9 -> 2 stall cycles, then ifid_flush=1 in cycle 3 if taken.
- **Multiply, MUL_LAT=4:** mul_busy=1 and pc_hold=idex_hold=exmem_flush=1 for exactly 3 cycles. jump=1 during that window yields ifid_flush=0.
- **Simultaneous events:** load_use and id_is_mul in the same cycle -> 1 stall cycle, then MUL_WAIT begins one edge later. Holding stall for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
- **Reset mid-MUL_WAIT:** all outputs go to 0 immediately, and the first cycle after release is RUN with mul_busy=0.
